// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: state encoding and transfer-mode constants for the DMA engine
package ram_dma_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dma_state_t;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/ram_dma_if.sv
// ram_dma_if: request/status handshake plus the RAM port driven by the engine
interface ram_dma_if #(parameter int ADDR_W = 8);
  logic              Start, Mode, Abort, Busy, Done, Err, MemWrite;
  logic [ADDR_W-1:0] SrcAddr, DstAddr;
  logic [ADDR_W:0]   Length, WordsDone;
  logic [31:0]       FillValue, Address, WD, RD;
  modport master (
    input  Start, Mode, SrcAddr, DstAddr, Length, FillValue, Abort, RD,
    output Busy, Done, Err, WordsDone, MemWrite, Address, WD
  );
  modport slave (
    output Start, Mode, SrcAddr, DstAddr, Length, FillValue, Abort, RD,
    input  Busy, Done, Err, WordsDone, MemWrite, Address, WD
  );
endinterface

// File: rtl/ram_dma.sv
// ram_dma: block copy/fill engine driving a single-port RAM with one-cycle read latency
module ram_dma import ram_dma_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input logic       CLK,
  input logic       RST_N,
  ram_dma_if.master bus
);
  localparam logic [ADDR_W+1:0] LIM = (ADDR_W+2)'(DEPTH);
  dma_state_t        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d;
  logic              mode_q, mode_d, err_q, err_d;
  logic [31:0]       fill_q, fill_d;
  logic [ADDR_W+1:0] src_end, dst_end;
  logic              range_bad, last;
  // Extra two bits keep the end-of-range sums from overflowing
  assign src_end   = {2'b0, bus.SrcAddr} + {1'b0, bus.Length};
  assign dst_end   = {2'b0, bus.DstAddr} + {1'b0, bus.Length};
  assign range_bad = dst_end > LIM || (bus.Mode == MODE_COPY && src_end > LIM);
  assign last      = cnt_q + 1'b1 == len_q;
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.Start) begin
        src_d   = bus.SrcAddr;
        dst_d   = bus.DstAddr;
        len_d   = bus.Length;
        mode_d  = bus.Mode;
        fill_d  = bus.FillValue;
        cnt_d   = '0;
        err_d   = range_bad;
        state_d = (range_bad || bus.Length == '0) ? DONE :
                  (bus.Mode == MODE_FILL) ? WRITE : READ;
      end
      READ: state_d = bus.Abort ? DONE : WRITE;
      WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        state_d = (bus.Abort || last) ? DONE : (mode_q == MODE_FILL) ? WRITE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  // Outputs decode only registered state, so reset clears them immediately
  assign bus.Busy      = state_q == READ || state_q == WRITE;
  assign bus.Done      = state_q == DONE;
  assign bus.Err       = err_q;
  assign bus.WordsDone = cnt_q;
  assign bus.MemWrite  = state_q == WRITE;
  assign bus.Address   = state_q == READ ? 32'(src_q) : state_q == WRITE ? 32'(dst_q) : 32'd0;
  assign bus.WD        = state_q != WRITE ? 32'd0 : mode_q == MODE_FILL ? fill_q : bus.RD;
endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: randomized copy/fill/abort traffic checked cycle by cycle against a transaction-level model
module tb_ram_dma;
  import ram_dma_pkg::*;
  typedef struct {
    logic        busy, mw, done, err;
    logic [31:0] addr, wd;
    logic [8:0]  wds;
  } rec_t;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  ram_dma_if #(.ADDR_W(8)) bus();
  ram_dma #(.ADDR_W(8), .DEPTH(256)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  logic [31:0] ram [256];
  logic [31:0] mm  [256];
  rec_t        exp_q[$];
  int          total = 0, bad = 0, cyc = 0, done_at = 0, mw_seen = 0;
  logic        chk_en = 1'b0, e_err = 1'b0, d_err = 1'b0;
  logic [8:0]  e_wds = '0, d_wds = '0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    bus.RD <= ram[bus.Address[7:0]];
    if (bus.MemWrite) ram[bus.Address[7:0]] = bus.WD;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic rec_t mk(input logic b, input logic w, input logic dn, input logic er,
                              input logic [31:0] a, input logic [31:0] d, input logic [8:0] ws);
    rec_t r;
    r.busy = b; r.mw = w; r.done = dn; r.err = er; r.addr = a; r.wd = d; r.wds = ws;
    return r;
  endfunction
  always @(negedge CLK) if (chk_en) begin
    if (exp_q.size() > 0) begin
      rec_t r;
      r = exp_q.pop_front();
      cyc++;
      chk("busy", 32'(bus.Busy), 32'(r.busy));
      chk("done", 32'(bus.Done), 32'(r.done));
      chk("memwrite", 32'(bus.MemWrite), 32'(r.mw));
      chk("address", bus.Address, r.addr);
      chk("wd", bus.WD, r.wd);
      chk("wordsdone", 32'(bus.WordsDone), 32'(r.wds));
      if (r.done) begin
        chk("err", 32'(bus.Err), 32'(r.err));
        e_err = r.err;
        e_wds = r.wds;
      end
      if (bus.MemWrite) mw_seen++;
      if (bus.Done) begin
        done_at = cyc;
        d_err = bus.Err;
        d_wds = bus.WordsDone;
      end
    end else begin
      chk("idle_busy", 32'(bus.Busy), 0);
      chk("idle_done", 32'(bus.Done), 0);
      chk("idle_mw", 32'(bus.MemWrite), 0);
      chk("idle_addr", bus.Address, 0);
      chk("idle_wd", bus.WD, 0);
      chk("idle_err", 32'(bus.Err), 32'(e_err));
      chk("idle_wds", 32'(bus.WordsDone), 32'(e_wds));
    end
  end
  // Builds the expected per-cycle trace from the transfer rules, then drives it with noisy inputs
  task automatic run(input logic m, input int src, input int dst, input int len,
                     input logic [31:0] fv, input int k);
    rec_t        q[$];
    int          c = 0, w = 0, nd = 0;
    logic        stop = 1'b0, rbad;
    logic [31:0] d;
    rbad = dst + len > 256 || (m == MODE_COPY && src + len > 256);
    if (!rbad) for (int i = 0; i < len && !stop; i++) begin
      if (m == MODE_COPY) begin
        c++;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'(src + i), 32'd0, 9'(w)));
        stop = c == k;
      end
      if (!stop) begin
        d = m == MODE_FILL ? fv : mm[src + i];
        c++;
        q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'(dst + i), d, 9'(w)));
        mm[dst + i] = d;
        w++;
        stop = c == k;
      end
    end
    q.push_back(mk(1'b0, 1'b0, 1'b1, rbad, 32'd0, 32'd0, 9'(w)));
    @(posedge CLK); #1;
    bus.Start = 1'b1; bus.Mode = m; bus.SrcAddr = 8'(src); bus.DstAddr = 8'(dst);
    bus.Length = 9'(len); bus.FillValue = fv; bus.Abort = 1'($urandom_range(0, 1));
    @(posedge CLK); #1;
    cyc = 0; done_at = 0; mw_seen = 0;
    exp_q = q;
    for (int j = 1; j <= q.size(); j++) begin
      bus.Abort = j == k;
      bus.Start = 1'($urandom_range(0, 1));
      bus.Mode = 1'($urandom_range(0, 1));
      bus.SrcAddr = 8'($urandom);
      bus.DstAddr = 8'($urandom);
      bus.Length = 9'($urandom);
      bus.FillValue = $urandom;
      @(posedge CLK); #1;
    end
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    for (int i = 0; i < 256; i++) if (ram[i] !== mm[i]) nd++;
    chk("mem_diff", 32'(nd), 0);
  endtask
  initial begin
    int   len, src, dst, k, r;
    logic m;
    logic [31:0] pre [5];
    pre[0] = 27; pre[1] = 28; pre[2] = 33; pre[3] = 15; pre[4] = 10;
    for (int i = 0; i < 256; i++) begin
      ram[i] = i < 5 ? pre[i] : 32'd0;
      mm[i]  = ram[i];
    end
    bus.Start = 1'b0; bus.Mode = MODE_COPY; bus.SrcAddr = '0; bus.DstAddr = '0;
    bus.Length = '0; bus.FillValue = '0; bus.Abort = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_err", 32'(bus.Err), 0);
    chk("rst_wds", 32'(bus.WordsDone), 0);
    chk("rst_mw", 32'(bus.MemWrite), 0);
    chk("rst_addr", bus.Address, 0);
    chk("rst_wd", bus.WD, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b1; bus.Mode = MODE_COPY; bus.SrcAddr = 8'd0; bus.DstAddr = 8'd10; bus.Length = 9'd5;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    chk("rst_pre_mw", 32'(bus.MemWrite), 1);
    RST_N = 1'b0;
    #1;
    chk("rst_async_mw", 32'(bus.MemWrite), 0);
    chk("rst_async_busy", 32'(bus.Busy), 0);
    chk("rst_async_addr", bus.Address, 0);
    @(posedge CLK); #1;
    chk("rst_mem10", ram[10], 27);
    chk("rst_mem11", ram[11], 0);
    mm[10] = 32'd27;
    RST_N = 1'b1;
    chk_en = 1'b1;
    run(MODE_COPY, 0, 10, 5, 32'd0, 5);
    chk("ab_wds", 32'(d_wds), 2);
    chk("ab_err", 32'(d_err), 0);
    chk("ab_done_cyc", 32'(done_at), 6);
    chk("ab_mem10", ram[10], 27);
    chk("ab_mem11", ram[11], 28);
    chk("ab_mem12", ram[12], 0);
    run(MODE_COPY, 0, 10, 5, 32'd0, 0);
    chk("cp_done_cyc", 32'(done_at), 11);
    chk("cp_mw_cycles", 32'(mw_seen), 5);
    chk("cp_wds", 32'(d_wds), 5);
    chk("cp_err", 32'(d_err), 0);
    for (int i = 0; i < 5; i++) chk("cp_mem", ram[10 + i], pre[i]);
    run(MODE_FILL, 0, 20, 3, 32'hDEADBEEF, 0);
    chk("fl_done_cyc", 32'(done_at), 4);
    chk("fl_mem20", ram[20], 32'hDEADBEEF);
    chk("fl_mem22", ram[22], 32'hDEADBEEF);
    chk("fl_mem23", ram[23], 0);
    run(MODE_COPY, 0, 0, 0, 32'd0, 0);
    chk("z_done_cyc", 32'(done_at), 1);
    chk("z_err", 32'(d_err), 0);
    chk("z_wds", 32'(d_wds), 0);
    chk("z_mw", 32'(mw_seen), 0);
    run(MODE_COPY, 250, 0, 10, 32'd0, 0);
    chk("e_done_cyc", 32'(done_at), 1);
    chk("e_err", 32'(d_err), 1);
    chk("e_mem0", ram[0], 27);
    chk("e_mem4", ram[4], 10);
    run(MODE_FILL, 250, 236, 20, 32'h5A5A, 0);
    chk("b_fill_edge_err", 32'(d_err), 0);
    run(MODE_FILL, 0, 237, 20, 32'h5A5A, 0);
    chk("b_fill_over_err", 32'(d_err), 1);
    run(MODE_COPY, 200, 0, 56, 32'd0, 0);
    chk("b_copy_edge_err", 32'(d_err), 0);
    run(MODE_COPY, 200, 0, 57, 32'd0, 0);
    chk("b_copy_over_err", 32'(d_err), 1);
    run(MODE_COPY, 30, 31, 6, 32'd0, 0);
    chk("ovl_mem36", ram[36], ram[30]);
    repeat (40) begin
      r   = $urandom_range(0, 9);
      m   = 1'($urandom_range(0, 1));
      len = r == 0 ? 0 : r == 1 ? $urandom_range(250, 300) : $urandom_range(1, 16);
      src = r == 1 ? $urandom_range(0, 6) : $urandom_range(0, 255);
      dst = r == 1 ? $urandom_range(0, 6) : $urandom_range(0, 3) == 0 ? (src + 1) % 256 : $urandom_range(0, 255);
      k   = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2 * len + 1) : 0;
      run(m, src, dst, len, $urandom, k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
